// File: rtl/alu_exmem_buf_pkg.sv
// ALU control codes and the default EX->MEM entry layout shared by the EX->MEM buffer files.
package alu_pkg;

  localparam logic [5:0] ALU_AND  = 6'd36;
  localparam logic [5:0] ALU_ANDI = 6'd12;
  localparam logic [5:0] ALU_OR   = 6'd37;
  localparam logic [5:0] ALU_ORI  = 6'd13;
  localparam logic [5:0] ALU_ADD  = 6'd32;
  localparam logic [5:0] ALU_ADDI = 6'd8;
  localparam logic [5:0] ALU_SUB  = 6'd34;
  localparam logic [5:0] ALU_SUBI = 6'd14;
  localparam logic [5:0] ALU_SLT  = 6'd42;
  localparam logic [5:0] ALU_SLTI = 6'd10;
  localparam logic [5:0] ALU_NOR  = 6'd39;
  localparam logic [5:0] ALU_BEQ  = 6'd4;
  localparam logic [5:0] ALU_BNE  = 6'd5;
  localparam logic [5:0] ALU_BGEZ = 6'd1;

  localparam int EX_DATA_W = 32;
  localparam int EX_REG_W  = 5;

  typedef struct packed {
    logic [EX_DATA_W-1:0] result;
    logic [EX_DATA_W-1:0] store_data;
    logic [EX_REG_W-1:0]  dest_reg;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } exmem_entry_t;

  function automatic logic is_branch_ctrl(input logic [5:0] ctrl);
    return (ctrl == ALU_BEQ) || (ctrl == ALU_BNE) || (ctrl == ALU_BGEZ);
  endfunction

  // Only signed adds raise the overflow trap; every other op ignores alu_ovf.
  function automatic logic is_trap_ctrl(input logic [5:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_ADDI);
  endfunction

endpackage

// File: rtl/alu_exmem_buf_skid2.sv
// Generic 2-entry valid/ready skid buffer: head H drives the output, skid S absorbs one beat of backpressure.
module exmem_skid2
  import alu_pkg::*;
#(
  parameter type entry_t = exmem_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  logic   h_vld_q, h_vld_d;
  logic   s_vld_q, s_vld_d;
  entry_t h_q, h_d;
  entry_t s_q, s_d;
  logic   push, pop;

  // Readiness comes straight from a flop so upstream never sees a combinational path from out_ready.
  assign in_ready  = !s_vld_q;
  assign out_valid = h_vld_q;
  assign out_data  = h_q;
  assign push      = in_valid && !s_vld_q;
  assign pop       = h_vld_q && out_ready;

  always_comb begin
    h_vld_d = h_vld_q;
    h_d     = h_q;
    s_vld_d = s_vld_q;
    s_d     = s_q;
    if (pop) begin
      h_vld_d = s_vld_q;
      s_vld_d = 1'b0;
      if (s_vld_q) begin
        h_d = s_q;
      end
    end
    if (push) begin
      if (!h_vld_q || pop) begin
        h_vld_d = 1'b1;
        h_d     = in_data;
      end else begin
        s_vld_d = 1'b1;
        s_d     = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      h_q     <= '0;
    end else begin
      h_vld_q <= h_vld_d;
      s_vld_q <= s_vld_d;
      h_q     <= h_d;
    end
  end

  // Skid payload is only observable once promoted to H, so it carries no reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

endmodule

// File: rtl/alu_exmem_buf.sv
// EX->MEM stage: enqueues ALU results into a 2-entry skid buffer, resolves branches, traps add overflow.
// Defining ALU_EXMEM_STATS_EN adds saturating stall/trap counters (stat_stall, stat_trap).
module alu_exmem_buf
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int PC_W     = 32,
  parameter int OVF_TRAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        control,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [PC_W-1:0]   br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_pc,
  output logic              exc_valid,
  output logic [PC_W-1:0]   exc_epc,
  input  logic              exc_ack
`ifdef ALU_EXMEM_STATS_EN
  ,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_trap
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  entry_t            in_entry, head_entry;
  logic              skid_in_ready;
  logic              accept, ctrl_branch, ctrl_ovf;
  logic              br_hit, trap_set, enq;
  logic              br_taken_q, br_taken_d;
  logic [PC_W-1:0]   br_pc_q, br_pc_d;
  logic              exc_valid_q, exc_valid_d;
  logic [PC_W-1:0]   exc_epc_q, exc_epc_d;

  // A pending trap flushes everything offered, so EX is never held off while it is up.
  assign in_ready    = exc_valid_q || skid_in_ready;
  assign accept      = in_valid && in_ready;
  assign ctrl_branch = is_branch_ctrl(control);
  assign ctrl_ovf    = (OVF_TRAP != 0) && is_trap_ctrl(control) && alu_ovf;
  assign br_hit      = accept && !exc_valid_q && ctrl_branch && alu_zero;
  assign trap_set    = accept && !exc_valid_q && ctrl_ovf;
  assign enq         = accept && !exc_valid_q && !ctrl_branch && !ctrl_ovf;

  assign in_entry = '{
    result:     alu_out,
    store_data: store_data,
    dest_reg:   dest_reg,
    reg_write:  reg_write,
    mem_read:   mem_read,
    mem_write:  mem_write
  };

  exmem_skid2 #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (enq),
    .in_ready  (skid_in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

  assign out_result     = head_entry.result;
  assign out_store_data = head_entry.store_data;
  assign out_dest_reg   = head_entry.dest_reg;
  assign out_reg_write  = head_entry.reg_write;
  assign out_mem_read   = head_entry.mem_read;
  assign out_mem_write  = head_entry.mem_write;

  // First trap wins: once exc_valid is up only exc_ack can change it, and epc is frozen.
  always_comb begin
    br_taken_d  = br_hit;
    br_pc_d     = br_hit ? br_target : br_pc_q;
    exc_valid_d = exc_valid_q ? !exc_ack : trap_set;
    exc_epc_d   = trap_set ? (pc_plus4 - PC_W'(4)) : exc_epc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q  <= 1'b0;
      br_pc_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_epc_q   <= '0;
    end else begin
      br_taken_q  <= br_taken_d;
      br_pc_q     <= br_pc_d;
      exc_valid_q <= exc_valid_d;
      exc_epc_q   <= exc_epc_d;
    end
  end

  assign br_taken  = br_taken_q;
  assign br_pc     = br_pc_q;
  assign exc_valid = exc_valid_q;
  assign exc_epc   = exc_epc_q;

`ifdef ALU_EXMEM_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_trap_q, stat_trap_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stat_stall_d = (in_valid && !in_ready) ? sat_inc(stat_stall_q) : stat_stall_q;
    stat_trap_d  = trap_set ? sat_inc(stat_trap_q) : stat_trap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= '0;
      stat_trap_q  <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_trap_q  <= stat_trap_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_trap  = stat_trap_q;
`endif

endmodule
